axil_mem_resp: RTL

- AXI-Lite responder (slave) that answers 24-bit-address, 512-bit-data read/write transactions from the memory-controller initiator.
- Services them from a single-port synchronous BRAM (1-cycle read latency) through one shared memory port.
- Sits on the target side of the fabric, directly in front of the packet/record storage RAM.

---
 rtl/axil_mem_resp.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/axil_mem_resp.sv
// AXI-Lite responder in front of a single-port synchronous BRAM (1-cycle read latency).
// Single-entry AW/W/AR holding buffers feed a round-robin arbiter sharing the one memory port.
module axil_mem_resp #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 512,
  parameter int MEM_AW = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {IDLE, WMEM, BRESP, RMEM, RWAIT, RRESP} state_e;

  state_e              state_q, state_d;
  logic                aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
  logic                awready_q, wready_q, arready_q;
  logic                aw_hs, w_hs, ar_hs;
  logic [MEM_AW-1:0]   aw_word_q, ar_word_q;
  logic                aw_ok_q, ar_ok_q;
  logic [DATA_W-1:0]   w_data_q;
  logic                rd_prio_q, grant_wr, grant_rd;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, rdata_q;
  logic [1:0]          bresp_q, rresp_q;
  logic                unused_addr_bits;

  // Byte offset within a 64-byte word carries no information for full-word accesses.
  assign unused_addr_bits = ^{awaddr[5:0], araddr[5:0]};

  assign aw_hs = awvalid & awready_q;
  assign w_hs  = wvalid  & wready_q;
  assign ar_hs = arvalid & arready_q;

  always_comb begin
    state_d  = state_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (aw_full_q && w_full_q && !(ar_full_q && rd_prio_q)) begin
          grant_wr = 1'b1;
          state_d  = aw_ok_q ? WMEM : BRESP;
        end else if (ar_full_q) begin
          grant_rd = 1'b1;
          state_d  = ar_ok_q ? RMEM : RRESP;
        end
      end
      WMEM:    state_d = BRESP;
      BRESP:   if (bready) state_d = IDLE;
      RMEM:    state_d = RWAIT;
      RWAIT:   state_d = RRESP;
      RRESP:   if (rready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant and handshake are mutually exclusive: a full buffer never shows ready.
  assign aw_full_d = grant_wr ? 1'b0 : (aw_full_q | aw_hs);
  assign w_full_d  = grant_wr ? 1'b0 : (w_full_q  | w_hs);
  assign ar_full_d = grant_rd ? 1'b0 : (ar_full_q | ar_hs);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aw_full_q   <= 1'b0;
      w_full_q    <= 1'b0;
      ar_full_q   <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      rd_prio_q   <= 1'b0;
      bresp_q     <= 2'b00;
      rresp_q     <= 2'b00;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      awready_q <= !aw_full_d;
      wready_q  <= !w_full_d;
      arready_q <= !ar_full_d;
      if (grant_wr) begin
        rd_prio_q   <= 1'b1;
        mem_addr_q  <= aw_word_q;
        mem_wdata_q <= w_data_q;
        bresp_q     <= aw_ok_q ? 2'b00 : 2'b11;
      end
      if (grant_rd) begin
        rd_prio_q  <= 1'b0;
        mem_addr_q <= ar_word_q;
        rresp_q    <= ar_ok_q ? 2'b00 : 2'b11;
        if (!ar_ok_q) rdata_q <= '0;
      end
      if (state_q == RWAIT) rdata_q <= mem_rdata;
    end
  end

  // Buffer payloads are only consulted while the matching full flag is set.
  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_word_q <= awaddr[MEM_AW+5:6];
      aw_ok_q   <= (awaddr[ADDR_W-1:MEM_AW+6] == '0);
    end
    if (w_hs) w_data_q <= wdata;
    if (ar_hs) begin
      ar_word_q <= araddr[MEM_AW+5:6];
      ar_ok_q   <= (araddr[ADDR_W-1:MEM_AW+6] == '0);
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign arready   = arready_q;
  assign bvalid    = (state_q == BRESP);
  assign rvalid    = (state_q == RRESP);
  assign bresp     = bresp_q;
  assign rresp     = rresp_q;
  assign rdata     = rdata_q;
  assign mem_en    = (state_q == WMEM) || (state_q == RMEM);
  assign mem_we    = (state_q == WMEM);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
